// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default bit timing, data width.
// Used by uart_tx and uart_rx so both ends of the link agree.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA_BURST = 3'd2,
      PARITY     = 3'd3,
      STOP       = 3'd4
   } uart_state_e;

   localparam int CLKS_PER_BIT_DEFAULT = 521;
   localparam int DATA_BITS            = 8;

   // odd=0 gives even parity, odd=1 gives odd parity
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps. bit_end flags the last
// clock of a bit, bit_pre the clock before it. Shared by the UART transmitter and receiver.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end,
   output logic bit_pre
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear || cnt == LAST) cnt <= '0;
      else                             cnt <= cnt + CNT_W'(1);
   end

   assign bit_end = (cnt == LAST);
   assign bit_pre = (cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, one stop bit.
// Parity frame bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic                 tx_clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_in,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_out,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   uart_state_e          state;
   logic [DATA_BITS-1:0] shift;
   logic [BIT_W-1:0]     bitpos;
   logic                 bit_end, bit_pre;
   logic                 timer_clr;
   logic                 accept;

   assign timer_clr = (state == IDLE);
   assign accept    = tx_valid & tx_ready;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk     (tx_clk),
      .rst     (rst),
      .clear   (timer_clr),
      .bit_end (bit_end),
      .bit_pre (bit_pre)
   );

   always_ff @(posedge tx_clk) begin
      if (rst) begin
         state    <= IDLE;
         shift    <= '0;
         bitpos   <= '0;
         tx_out   <= 1'b1;
         tx_ready <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  shift    <= tx_in;
                  state    <= START;
                  tx_out   <= 1'b0;
                  tx_ready <= 1'b0;
                  tx_busy  <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  state  <= DATA_BURST;
                  bitpos <= '0;
                  tx_out <= shift[0];
               end
            end
            DATA_BURST: begin
               if (bit_end) begin
                  if (bitpos == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                     state  <= PARITY;
                     tx_out <= parity_bit(shift, PARITY_ODD);
`else
                     state  <= STOP;
                     tx_out <= 1'b1;
`endif
                  end else begin
                     bitpos <= bitpos + BIT_W'(1);
                     tx_out <= shift[bitpos + BIT_W'(1)];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state  <= STOP;
                  tx_out <= 1'b1;
               end
            end
`endif
            STOP: begin
               // Outputs are registered, so the final-cycle flags are raised one clock early
               if (bit_pre) begin
                  tx_done  <= 1'b1;
                  tx_ready <= 1'b1;
               end
               if (bit_end) begin
                  if (accept) begin
                     shift    <= tx_in;
                     state    <= START;
                     tx_out   <= 1'b0;
                     tx_ready <= 1'b0;
                  end else begin
                     state   <= IDLE;
                     tx_busy <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               tx_out   <= 1'b1;
               tx_ready <= 1'b1;
               tx_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: reset/handshake vector table, hand sequences for frame corner cases,
// and random traffic checked against a per-cycle line model and a behavioural receiver.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int F = NB * C;

   logic       tx_clk   = 1'b0;
   logic       rst      = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_in    = 8'h00;
   logic       tx_ready, tx_out, tx_busy, tx_done;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 tx_clk = ~tx_clk;

   uart_tx #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) dut (
      .tx_clk(tx_clk), .rst(rst), .tx_in(tx_in), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done)
   );

`ifdef UART_TX_PARITY_EN
   logic o_ready, o_out, o_busy, o_done;
   uart_tx #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b1)) dut_odd (
      .tx_clk(tx_clk), .rst(rst), .tx_in(tx_in), .tx_valid(tx_valid),
      .tx_ready(o_ready), .tx_out(o_out), .tx_busy(o_busy), .tx_done(o_done)
   );
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Line model: queue of expected tx_out values, one per upcoming cycle
   bit         line_q[$];
   logic [7:0] acc_q[$];

   always @(posedge tx_clk) begin
      if (rst) begin
         line_q.delete();
         acc_q.delete();
      end else begin
         bit rdy;
         bit v;
         rdy = (line_q.size() <= 1);
         if (line_q.size() > 0) void'(line_q.pop_front());
         if (tx_valid && rdy) begin
            for (int b = 0; b < NB; b++) begin
               if (b == 0)              v = 1'b0;
               else if (b == NB - 1)    v = 1'b1;
               else if (b <= DATA_BITS) v = tx_in[b-1];
               else                     v = ^tx_in;
               repeat (C) line_q.push_back(v);
            end
            acc_q.push_back(tx_in);
         end
      end
   end

   always @(negedge tx_clk) begin
      if (chk_en) begin
         bit eo;
         eo = (line_q.size() > 0) ? line_q[0] : 1'b1;
         chk("line", {tx_out, tx_ready, tx_busy, tx_done},
             {eo, line_q.size() <= 1, line_q.size() > 0, line_q.size() == 1});
      end
   end

   // Behavioural receiver sampling mid-bit
   bit         rx_act = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_sh  = 8'h00;
   logic [7:0] rx_last = 8'h00;

   always @(negedge tx_clk) begin
      int k;
      if (rst || !chk_en) rx_act = 1'b0;
      else if (!rx_act) begin
         if (tx_out === 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if ((rx_cnt % C) == C / 2) begin
            k = rx_cnt / C;
            if (k >= 1 && k <= 8) rx_sh[k-1] = tx_out;
`ifdef UART_TX_PARITY_EN
            if (k == 9) chk("rx_parity", tx_out, ^rx_sh);
`endif
            if (k == NB - 1) begin
               chk("rx_stop", tx_out, 1);
               rx_last = rx_sh;
               chk("rx_pending", acc_q.size() != 0, 1);
               if (acc_q.size() != 0) chk("rx_byte", rx_sh, acc_q.pop_front());
               rx_act = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge tx_clk);
      #1;
   endtask

   task automatic wait_accept(output int n);
      n = 0;
      while (n < 3 * F) begin
         @(negedge tx_clk);
         if (tx_ready) begin
            tick();
            return;
         end
         n++;
      end
      chk("accept_timeout", tx_ready, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3 * F; i++) begin
         @(negedge tx_clk);
         if (!tx_busy) break;
      end
      chk("idle_reached", tx_busy, 0);
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      tx_valid = 1'b1;
      tx_in    = b;
      wait_accept(n);
      tx_valid = 1'b0;
   endtask

   typedef struct {
      bit         r;
      bit         v;
      logic [7:0] d;
      logic [3:0] exp;   // {tx_out, tx_ready, tx_busy, tx_done}
   } vec_t;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t       tbl[8];
      int         n, dcnt, dpos;
      logic [10:0] a5_exp;

      tbl[0] = '{1'b1, 1'b0, 8'h00, 4'b1100};
      tbl[1] = '{1'b1, 1'b0, 8'h00, 4'b1100};
      tbl[2] = '{1'b1, 1'b1, 8'hA5, 4'b1100};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 4'b1100};
      tbl[4] = '{1'b0, 1'b1, 8'h3C, 4'b0010};
      tbl[5] = '{1'b0, 1'b0, 8'h3C, 4'b0010};
      tbl[6] = '{1'b1, 1'b0, 8'h00, 4'b1100};
      tbl[7] = '{1'b0, 1'b0, 8'h00, 4'b1100};
      for (int i = 0; i < 8; i++) begin
         rst      = tbl[i].r;
         tx_valid = tbl[i].v;
         tx_in    = tbl[i].d;
         tick();
         chk($sformatf("vec%0d", i), {tx_out, tx_ready, tx_busy, tx_done}, tbl[i].exp);
      end
      rst      = 1'b0;
      tx_valid = 1'b0;
      chk_en   = 1'b1;

      repeat (50) tick();
      chk("idle50", {tx_out, tx_ready, tx_busy}, 3'b110);

      // 0xA5: explicit bit pattern and tx_done timing
`ifdef UART_TX_PARITY_EN
      a5_exp = 11'b10101001010;
`else
      a5_exp = 11'b01101001010;
`endif
      tx_valid = 1'b1;
      tx_in    = 8'hA5;
      tick();
      tx_valid = 1'b0;
      dcnt = 0;
      dpos = -1;
      for (int e = 1; e <= F; e++) begin
         if (((e - 1) % C) == C / 2) chk("a5_bit", tx_out, a5_exp[(e-1)/C]);
         if (tx_done) begin
            dcnt++;
            dpos = e;
         end
         if (e == F) chk("a5_ready_last", tx_ready, 1);
         tick();
      end
      chk("a5_done_count", dcnt, 1);
      chk("a5_done_cycle", dpos, F);

      // back-to-back 0x00 then 0xFF with tx_valid held
      tx_valid = 1'b1;
      tx_in    = 8'h00;
      tick();
      tx_in = 8'hFF;
      dcnt  = 0;
      for (int e = 1; e <= 2 * F; e++) begin
         if (tx_done) dcnt++;
         if (e == F) chk("b2b_stop_high", tx_out, 1);
         if (e == F + 1) begin
            chk("b2b_start_low", tx_out, 0);
            tx_valid = 1'b0;
         end
         tick();
      end
      chk("b2b_done_count", dcnt, 2);
      chk("b2b_idle_after", tx_busy, 0);

      // reset mid-frame while sending 0x3C, then 0x81
      tx_valid = 1'b1;
      tx_in    = 8'h3C;
      tick();
      tx_valid = 1'b0;
      dcnt = 0;
      for (int e = 1; e < 15; e++) begin
         if (tx_done) dcnt++;
         tick();
      end
      rst = 1'b1;
      tick();
      chk("rst_outputs", {tx_out, tx_ready, tx_busy, tx_done}, 4'b1100);
      chk("rst_no_done", dcnt, 0);
      rst = 1'b0;
      tick();
      send(8'h81);
      wait_idle();
      chk("rt_81", rx_last, 8'h81);

      // backpressure: tx_in changes mid-frame, accepted only in the final stop cycle
      tx_valid = 1'b1;
      tx_in    = 8'h12;
      tick();
      tx_in = 8'h34;
      repeat (F / 2) tick();
      tx_in = 8'h56;
      wait_accept(n);
      tx_valid = 1'b0;
      chk("bp_accept_wait", n, F - 1 - F / 2);
      wait_idle();
      chk("bp_second_byte", rx_last, 8'h56);

`ifdef UART_TX_PARITY_EN
      tx_valid = 1'b1;
      tx_in    = 8'h07;
      tick();
      tx_valid = 1'b0;
      repeat (9 * C + C / 2) tick();
      chk("par_even", tx_out, 1);
      chk("par_odd", o_out, 0);
      wait_idle();
`endif

      send(8'h55);
      wait_idle();
      chk("rt_55", rx_last, 8'h55);

      // random traffic with gaps and back-to-back frames
      for (int i = 0; i < 40; i++) begin
         tx_in    = 8'($urandom);
         tx_valid = 1'b1;
         wait_accept(n);
         if ($urandom_range(0, 2) != 0) begin
            tx_valid = 1'b0;
            repeat ($urandom_range(0, 2 * F)) tick();
         end
      end
      tx_valid = 1'b0;
      wait_idle();
      repeat (C) tick();
      chk("all_received", acc_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
